// File: rtl/int_frame_parser.sv
// Frame assembler for the int_receiver word stream: SYNC, HEADER, NUM_WORDS payload
// words and an XOR checksum. Good frames are published with a one-cycle strobe.
module int_frame_parser #(
    parameter int          NUM_WORDS   = 6,
    parameter logic [31:0] SYNC_WORD   = 32'hAAAAAAAA,
    parameter logic [31:0] TIMEOUT_CYC = 32'd270000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      int_avail,
    input  logic [31:0]               o_int,
    output logic                      frame_valid,
    output logic [31:0]               header,
    output logic [32*NUM_WORDS-1:0]   payload,
    output logic [15:0]               frame_cnt,
    output logic [15:0]               err_cnt,
    output logic                      busy
);
    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_CHECK   = 2'd3;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_WORDS - 1);
    localparam logic [31:0] TO_LAST  = TIMEOUT_CYC - 32'd1;

    logic [1:0]                       r_state;
    logic                             r_avail_q;
    logic [3:0]                       r_idx;
    logic [31:0]                      r_csum;
    logic [31:0]                      r_timer;
    logic [31:0]                      r_hdr_sh;
    logic [NUM_WORDS-1:0][31:0]       r_shadow;
    logic [31:0]                      r_header;
    logic [NUM_WORDS-1:0][31:0]       r_payload;
    logic                             r_valid;
    logic [15:0]                      r_frame_cnt;
    logic [15:0]                      r_err_cnt;

    logic w_event;
    logic w_timeout;
    logic w_good;
    logic w_bad;
    logic w_err_inc;

    assign w_event   = int_avail & ~r_avail_q;
    // A word event on the same cycle as expiry takes priority over the timeout.
    assign w_timeout = (r_state != S_HUNT) && !w_event && (r_timer >= TO_LAST);
    assign w_good    = (r_state == S_CHECK) && w_event && (o_int == r_csum);
    assign w_bad     = (r_state == S_CHECK) && w_event && (o_int != r_csum);
    assign w_err_inc = w_timeout | w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_avail_q   <= 1'b0;
            r_idx       <= 4'd0;
            r_csum      <= 32'd0;
            r_timer     <= 32'd0;
            r_hdr_sh    <= 32'd0;
            r_shadow    <= '0;
            r_header    <= 32'd0;
            r_payload   <= '0;
            r_valid     <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_avail_q <= int_avail;
            r_valid   <= 1'b0;

            case (r_state)
                S_HUNT: begin
                    if (w_event && o_int == SYNC_WORD) r_state <= S_HEADER;
                end
                S_HEADER: begin
                    if (w_event) begin
                        r_hdr_sh <= o_int;
                        r_csum   <= o_int;
                        r_idx    <= 4'd0;
                        r_state  <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_event) begin
                        for (int i = 0; i < NUM_WORDS; i++)
                            if (r_idx == 4'(i)) r_shadow[i] <= o_int;
                        r_csum <= r_csum ^ o_int;
                        r_idx  <= r_idx + 4'd1;
                        if (r_idx == LAST_IDX) r_state <= S_CHECK;
                    end
                end
                default: begin
                    if (w_event) r_state <= S_HUNT;
                end
            endcase

            if (w_good) begin
                r_header    <= r_hdr_sh;
                r_payload   <= r_shadow;
                r_valid     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;

            // Timer idles in HUNT and restarts on every word; expiry abandons the frame.
            if (w_event || r_state == S_HUNT) begin
                r_timer <= 32'd0;
            end else if (w_timeout) begin
                r_timer <= 32'd0;
                r_state <= S_HUNT;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    assign frame_valid = r_valid;
    assign header      = r_header;
    assign payload     = r_payload;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;
    assign busy        = (r_state != S_HUNT);

endmodule

// File: tb/tb_int_frame_parser.sv
// Bench for int_frame_parser: words driven as int_avail pulses, good frames queued
// on a scoreboard and matched against each frame_valid strobe.
`timescale 1ns/1ps
module tb_int_frame_parser;
    localparam int          NW   = 6;
    localparam logic [31:0] SYNC = 32'hAAAAAAAA;
    localparam logic [31:0] TO   = 32'd200;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               int_avail = 1'b0;
    logic [31:0]        o_int = 32'd0;
    logic               frame_valid;
    logic [31:0]        header;
    logic [32*NW-1:0]   payload;
    logic [15:0]        frame_cnt;
    logic [15:0]        err_cnt;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_seen  = 0;
    logic [32*NW+31:0] sb[$];
    logic [32*NW+31:0] sb_exp;

    int_frame_parser #(.NUM_WORDS(NW), .SYNC_WORD(SYNC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .int_avail(int_avail), .o_int(o_int),
        .frame_valid(frame_valid), .header(header), .payload(payload),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            fv_seen++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: frame_valid with hdr %h, none expected", header);
            end else begin
                sb_exp = sb.pop_front();
                if ({payload, header} !== sb_exp)
                    $display("FAIL sb_frame: got %h_%h want %h", payload, header, sb_exp);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [32*NW-1:0] mkpl(input logic [31:0] base);
        logic [32*NW-1:0] p;
        for (int i = 0; i < NW; i++) p[i*32 +: 32] = base + 32'(i);
        return p;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; int_avail = 1'b0; o_int = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        @(posedge clk); #1;
        o_int = w; int_avail = 1'b1;
        repeat (2) @(posedge clk);
        #1 int_avail = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [32*NW-1:0] pl, input bit good);
        logic [31:0] cs;
        cs = hdr;
        for (int i = 0; i < NW; i++) cs = cs ^ pl[i*32 +: 32];
        if (!good) cs = cs ^ 32'd1;
        else sb.push_back({pl, hdr});
        send_word(SYNC);
        send_word(hdr);
        for (int i = 0; i < NW; i++) send_word(pl[i*32 +: 32]);
        send_word(cs);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({frame_valid, header, payload, frame_cnt, err_cnt, busy} !== '0)
            $display("FAIL reset_outputs: got fv=%b hdr=%h fc=%h ec=%h busy=%b want all 0",
                     frame_valid, header, frame_cnt, err_cnt, busy);
        else n_pass++;
    endtask

    task automatic test_good_and_bad();
        int fv0;
        logic [31:0] h0;
        logic [32*NW-1:0] p0;
        do_reset();
        fv0 = fv_seen;
        send_frame(32'h00000001, mkpl(32'd1), 1'b1);
        n_checks++;
        if (fv_seen - fv0 !== 1) $display("FAIL good_fv_count: got %0d want 1", fv_seen - fv0); else n_pass++;
        n_checks++;
        if (frame_cnt !== 16'd1) $display("FAIL good_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
        n_checks++;
        if (payload[31:0] !== 32'd1) $display("FAIL good_pl_w0: got %h want 1", payload[31:0]); else n_pass++;
        n_checks++;
        if (payload[191:160] !== 32'd6) $display("FAIL good_pl_w5: got %h want 6", payload[191:160]); else n_pass++;
        h0 = header; p0 = payload; fv0 = fv_seen;
        send_frame(32'h00000001, mkpl(32'd1), 1'b0);
        n_checks++;
        if (fv_seen - fv0 !== 0) $display("FAIL bad_fv_count: got %0d want 0", fv_seen - fv0); else n_pass++;
        n_checks++;
        if (err_cnt !== 16'd1) $display("FAIL bad_err_cnt: got %0d want 1", err_cnt); else n_pass++;
        n_checks++;
        if (frame_cnt !== 16'd1 || header !== 32'd1 || payload !== mkpl(32'd1))
            $display("FAIL bad_outputs_held: got fc=%0d hdr=%h want fc=1 hdr=1 and previous payload", frame_cnt, header);
        else n_pass++;
        n_checks++;
        if (h0 !== 32'd1 || p0 !== mkpl(32'd1)) $display("FAIL good_header_payload: got hdr %h want 1", h0); else n_pass++;
    endtask

    task automatic test_garbage();
        int fv0;
        do_reset();
        fv0 = fv_seen;
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL garbage_busy: got %b want 0", busy); else n_pass++;
        send_frame(32'h00000001, mkpl(32'd1), 1'b1);
        n_checks++;
        if (err_cnt !== 16'd0 || frame_cnt !== 16'd1 || fv_seen - fv0 !== 1)
            $display("FAIL garbage_counts: got ec=%0d fc=%0d fv=%0d want 0 1 1", err_cnt, frame_cnt, fv_seen - fv0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        send_word(SYNC);
        send_word(32'h0000_0002);
        for (int i = 0; i < 3; i++) send_word(32'h100 + 32'(i));
        repeat (int'(TO) - 10) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt !== 16'd0 || busy !== 1'b1)
            $display("FAIL timeout_early: got ec=%0d busy=%b want 0 1", err_cnt, busy);
        else n_pass++;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt !== 16'd1 || busy !== 1'b0)
            $display("FAIL timeout_fired: got ec=%0d busy=%b want 1 0", err_cnt, busy);
        else n_pass++;
        send_frame(32'h00000002, mkpl(32'd10), 1'b1);
        n_checks++;
        if (frame_cnt !== 16'd1 || err_cnt !== 16'd1)
            $display("FAIL timeout_recover: got fc=%0d ec=%0d want 1 1", frame_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_held_level();
        logic [32*NW-1:0] pl;
        logic [31:0] cs;
        do_reset();
        pl = mkpl(32'h20);
        cs = 32'h0000_0003;
        for (int i = 0; i < NW; i++) cs = cs ^ pl[i*32 +: 32];
        @(posedge clk); #1;
        o_int = SYNC; int_avail = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL held_busy: got %b want 1", busy); else n_pass++;
        int_avail = 1'b0;
        sb.push_back({pl, 32'h0000_0003});
        send_word(32'h0000_0003);
        for (int i = 0; i < NW; i++) send_word(pl[i*32 +: 32]);
        send_word(cs);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (frame_cnt !== 16'd1 || err_cnt !== 16'd0)
            $display("FAIL held_single_event: got fc=%0d ec=%0d want 1 0", frame_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_frame(32'h00000004, mkpl(32'h30), 1'b1);
        send_word(SYNC);
        send_word(32'h0000_0005);
        for (int i = 0; i < 4; i++) send_word(32'h40 + 32'(i));
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++;
        if ({frame_valid, header, payload, frame_cnt, err_cnt, busy} !== '0)
            $display("FAIL midrst_outputs: got hdr=%h fc=%0d ec=%0d busy=%b want all 0",
                     header, frame_cnt, err_cnt, busy);
        else n_pass++;
        send_frame(32'h00000006, mkpl(32'h50), 1'b1);
        n_checks++;
        if (frame_cnt !== 16'd1 || header !== 32'h6)
            $display("FAIL midrst_next: got fc=%0d hdr=%h want 1 6", frame_cnt, header);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [32*NW-1:0] pl;
        int fv0;
        do_reset();
        fv0 = fv_seen;
        pl = mkpl(32'h60);
        pl[2*32 +: 32] = SYNC;
        send_frame(SYNC, pl, 1'b1);
        send_frame(32'h00000007, mkpl(32'h70), 1'b1);
        n_checks++;
        if (frame_cnt !== 16'd2 || err_cnt !== 16'd0 || fv_seen - fv0 !== 2)
            $display("FAIL b2b_counts: got fc=%0d ec=%0d fv=%0d want 2 0 2", frame_cnt, err_cnt, fv_seen - fv0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_and_bad();
        test_garbage();
        test_timeout();
        test_held_level();
        test_mid_reset();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d frames pending want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
